// File: rtl/ast_width_reducer.sv
// ast_width_reducer: Avalon-ST width reducer.
// Each wide sink beat is held in a one-beat buffer and sent as
// DATA_IN_W/DATA_OUT_W narrow words, least significant word first.
// On an eop beat, only the words that hold valid bytes are sent.
// Optional macro AST_WIDTH_REDUCER_REG_READY_EN: when defined, snk_ready_o
// comes only from the buffer state, so there is no combinational path from
// src_ready_i. This costs one idle cycle per beat.
module ast_width_reducer #(
  parameter int DATA_IN_W   = 64,
  parameter int DATA_OUT_W  = 16,
  parameter int EMPTY_IN_W  = 3,
  parameter int EMPTY_OUT_W = 1,
  parameter int CHANNEL_W   = 10
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic [DATA_IN_W-1:0]   snk_data_i,
  input  logic                   snk_startofpacket_i,
  input  logic                   snk_endofpacket_i,
  input  logic                   snk_valid_i,
  input  logic [EMPTY_IN_W-1:0]  snk_empty_i,
  input  logic [CHANNEL_W-1:0]   snk_channel_i,
  output logic                   snk_ready_o,
  output logic [DATA_OUT_W-1:0]  src_data_o,
  output logic                   src_startofpacket_o,
  output logic                   src_endofpacket_o,
  output logic                   src_valid_o,
  output logic [EMPTY_OUT_W-1:0] src_empty_o,
  output logic [CHANNEL_W-1:0]   src_channel_o,
  input  logic                   src_ready_i
);

  localparam int N         = DATA_IN_W / DATA_OUT_W;
  localparam int BYTES_IN  = DATA_IN_W / 8;
  localparam int BYTES_OUT = DATA_OUT_W / 8;
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1;

  logic [DATA_IN_W-1:0]   buf_data;
  logic                   buf_valid;
  logic                   buf_sop;
  logic                   buf_eop;
  logic [CHANNEL_W-1:0]   buf_channel;
  logic [IDX_W-1:0]       buf_last_idx;
  logic [EMPTY_OUT_W-1:0] buf_empty;
  logic [IDX_W-1:0]       idx;

  int                     vb;
  int                     words;
  logic [IDX_W-1:0]       new_last_idx;
  logic [EMPTY_OUT_W-1:0] new_empty;
  logic [DATA_OUT_W-1:0]  word_sel;
  logic                   on_last;
  logic                   out_en;
  logic                   out_fire;
  logic                   in_fire;
  logic                   ready;

  // Work out the last word index and the empty count of that last word for the incoming beat.
  always_comb begin
    vb = BYTES_IN - int'(snk_empty_i);
    if (vb < 1) begin
      vb = 1;
    end
    words = (vb + BYTES_OUT - 1) / BYTES_OUT;
    new_last_idx = IDX_W'(N - 1);
    new_empty = '0;
    if (snk_endofpacket_i) begin
      new_last_idx = IDX_W'(words - 1);
      new_empty = EMPTY_OUT_W'(words * BYTES_OUT - vb);
    end
  end

  // Select the buffered word that the counter currently points at.
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        word_sel = buf_data[k*DATA_OUT_W +: DATA_OUT_W];
      end
    end
  end

  assign on_last  = (idx == buf_last_idx);
  assign out_en   = buf_valid && !srst;
  assign out_fire = buf_valid && src_ready_i;
  assign in_fire  = snk_valid_i && ready;

`ifdef AST_WIDTH_REDUCER_REG_READY_EN
  assign ready = !srst && !buf_valid;
`else
  assign ready = !srst && (!buf_valid || (src_ready_i && on_last));
`endif

  assign snk_ready_o         = ready;
  assign src_valid_o         = out_en;
  assign src_data_o          = out_en ? word_sel : '0;
  assign src_startofpacket_o = out_en && buf_sop && (idx == '0);
  assign src_endofpacket_o   = out_en && buf_eop && on_last;
  assign src_empty_o         = src_endofpacket_o ? buf_empty : '0;
  assign src_channel_o       = out_en ? buf_channel : '0;

  // Advance through the buffered words, and reload the buffer when a new beat is accepted.
  always_ff @(posedge clk) begin
    if (srst) begin
      buf_valid    <= 1'b0;
      idx          <= '0;
      buf_data     <= '0;
      buf_sop      <= 1'b0;
      buf_eop      <= 1'b0;
      buf_channel  <= '0;
      buf_last_idx <= '0;
      buf_empty    <= '0;
    end else begin
      if (out_fire) begin
        if (on_last) begin
          idx       <= '0;
          buf_valid <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (in_fire) begin
        buf_valid    <= 1'b1;
        buf_data     <= snk_data_i;
        buf_sop      <= snk_startofpacket_i;
        buf_eop      <= snk_endofpacket_i;
        buf_channel  <= snk_channel_i;
        buf_last_idx <= new_last_idx;
        buf_empty    <= new_empty;
      end
    end
  end

endmodule

// File: tb/tb_ast_width_reducer.sv
// tb_ast_width_reducer: self-checking bench for ast_width_reducer.
// A queue of expected output words is built from each accepted beat, using
// byte arithmetic. A single compare process checks the DUT against this queue
// on every falling edge. Directed cases check the model against literal values.
module tb_ast_width_reducer;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    logic        empty;
    logic [9:0]  ch;
    int          cyc;
  } word_t;

  logic        clk = 1'b0;
  logic        srst;
  logic [63:0] snk_data_i;
  logic        snk_startofpacket_i;
  logic        snk_endofpacket_i;
  logic        snk_valid_i;
  logic [2:0]  snk_empty_i;
  logic [9:0]  snk_channel_i;
  logic        snk_ready_o;
  logic [15:0] src_data_o;
  logic        src_startofpacket_o;
  logic        src_endofpacket_o;
  logic        src_valid_o;
  logic [0:0]  src_empty_o;
  logic [9:0]  src_channel_o;
  logic        src_ready_i;

  int    checks = 0;
  int    failures = 0;
  int    cycle = 0;
  int    ready_mode = 0;
  word_t q[$];
  word_t log_q[$];

`ifdef AST_WIDTH_REDUCER_REG_READY_EN
  localparam int SPAN16 = 18;
`else
  localparam int SPAN16 = 15;
`endif

  ast_width_reducer #(
    .DATA_IN_W(64), .DATA_OUT_W(16), .EMPTY_IN_W(3), .EMPTY_OUT_W(1), .CHANNEL_W(10)
  ) dut (
    .clk(clk),
    .srst(srst),
    .snk_data_i(snk_data_i),
    .snk_startofpacket_i(snk_startofpacket_i),
    .snk_endofpacket_i(snk_endofpacket_i),
    .snk_valid_i(snk_valid_i),
    .snk_empty_i(snk_empty_i),
    .snk_channel_i(snk_channel_i),
    .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o),
    .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o(src_endofpacket_o),
    .src_valid_o(src_valid_o),
    .src_empty_o(src_empty_o),
    .src_channel_o(src_channel_o),
    .src_ready_i(src_ready_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Expected words of one beat, derived from valid byte count
  task automatic pushBeat(input logic [63:0] d, input logic sop, input logic eop,
                          input logic [2:0] empty, input logic [9:0] ch);
    int    vb;
    int    nw;
    word_t w;
    vb = eop ? 8 - int'(empty) : 8;
    nw = (vb + 1) / 2;
    for (int k = 0; k < nw; k++) begin
      w.data  = d[k*16 +: 16];
      w.sop   = sop && (k == 0);
      w.eop   = eop && (k == nw - 1);
      w.empty = w.eop ? 1'(nw * 2 - vb) : 1'b0;
      w.ch    = ch;
      w.cyc   = 0;
      q.push_back(w);
    end
  endtask

  // Downstream ready: forced high or randomly toggled
  initial begin
    src_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      src_ready_i = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Compare process: DUT versus queue model on every falling edge
  logic        have_prev = 1'b0;
  logic [29:0] prev_out;
  initial begin
    logic [29:0] cur_out;
    logic        exp_ready;
    word_t       w;
    forever begin
      @(negedge clk);
      cycle++;
      cur_out = {src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o,
                 src_empty_o, src_channel_o};
      if (srst) begin
        q.delete();
        have_prev = 1'b0;
        checkOutput("rst_outputs", {34'd0, cur_out}, 64'd0);
        checkOutput("rst_snk_ready", {63'd0, snk_ready_o}, 64'd0);
      end else begin
        if (have_prev) begin
          checkOutput("stable_while_stalled", {34'd0, cur_out}, {34'd0, prev_out});
        end
`ifdef AST_WIDTH_REDUCER_REG_READY_EN
        exp_ready = (q.size() == 0);
`else
        exp_ready = (q.size() == 0) || (src_ready_i && q.size() == 1);
`endif
        checkOutput("snk_ready", {63'd0, snk_ready_o}, {63'd0, exp_ready});
        checkOutput("src_valid", {63'd0, src_valid_o}, {63'd0, (q.size() != 0)});
        if (src_valid_o && q.size() != 0) begin
          checkOutput("src_data", {48'd0, src_data_o}, {48'd0, q[0].data});
          checkOutput("src_sop", {63'd0, src_startofpacket_o}, {63'd0, q[0].sop});
          checkOutput("src_eop", {63'd0, src_endofpacket_o}, {63'd0, q[0].eop});
          checkOutput("src_empty", {63'd0, src_empty_o}, {63'd0, q[0].empty});
          checkOutput("src_channel", {54'd0, src_channel_o}, {54'd0, q[0].ch});
          if (src_ready_i) begin
            w = q.pop_front();
            w.cyc = cycle;
            log_q.push_back(w);
          end
        end
        have_prev = src_valid_o && !src_ready_i;
        prev_out  = cur_out;
        if (snk_valid_i && snk_ready_o) begin
          pushBeat(snk_data_i, snk_startofpacket_i, snk_endofpacket_i, snk_empty_i, snk_channel_i);
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic applyStimulus(input logic [63:0] d, input logic sop, input logic eop,
                               input logic [2:0] empty, input logic [9:0] ch);
    logic acc;
    acc = 1'b0;
    snk_data_i = d;
    snk_startofpacket_i = sop;
    snk_endofpacket_i = eop;
    snk_empty_i = empty;
    snk_channel_i = ch;
    snk_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (snk_ready_o) begin
        acc = 1'b1;
        break;
      end
    end
    checkOutput("accept_timeout", {63'd0, acc}, 64'd1);
    @(posedge clk);
    #1;
    snk_valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 1000 && q.size() != 0; i++) @(negedge clk);
    checkOutput("drain_timeout", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Directed cases, random traffic and reset mid-beat
  initial begin
    logic [15:0] exp1 [4];
    int          npk;
    int          nb;
    srst = 1'b1;
    snk_data_i = '0;
    snk_startofpacket_i = 1'b0;
    snk_endofpacket_i = 1'b0;
    snk_valid_i = 1'b0;
    snk_empty_i = '0;
    snk_channel_i = '0;
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {63'd0, snk_ready_o}, 64'd1);
    @(posedge clk);
    #1;

    // Full beat, sop and eop together
    log_q.delete();
    exp1[0] = 16'h1111; exp1[1] = 16'h2222; exp1[2] = 16'h3333; exp1[3] = 16'h4444;
    applyStimulus(64'h4444_3333_2222_1111, 1'b1, 1'b1, 3'd0, 10'd5);
    waitDrain();
    checkOutput("t1_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("t1_data", {48'd0, log_q[k].data}, {48'd0, exp1[k]});
        checkOutput("t1_channel", {54'd0, log_q[k].ch}, 64'd5);
        checkOutput("t1_cycle", 64'(log_q[k].cyc - log_q[0].cyc), 64'(k));
      end
      checkOutput("t1_sop", {62'd0, log_q[0].sop, log_q[3].sop}, 64'b10);
      checkOutput("t1_eop", {62'd0, log_q[0].eop, log_q[3].eop}, 64'b01);
      checkOutput("t1_empty", {63'd0, log_q[3].empty}, 64'd0);
    end

    // empty=3, five valid bytes, three words
    log_q.delete();
    applyStimulus(64'h0000_00EE_DDCC_BBAA, 1'b1, 1'b1, 3'd3, 10'd1);
    waitDrain();
    checkOutput("t2_count", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      checkOutput("t2_last", {29'd0, log_q[2].eop, log_q[2].empty, log_q[2].data, 18'd0},
                  {29'd0, 1'b1, 1'b1, 16'h00EE, 18'd0});
    end

    // empty=7, single word with sop and eop
    log_q.delete();
    applyStimulus(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 3'd7, 10'd2);
    waitDrain();
    checkOutput("t3_count", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      checkOutput("t3_word", {45'd0, log_q[0].sop, log_q[0].eop, log_q[0].empty, log_q[0].data},
                  {45'd0, 1'b1, 1'b1, 1'b1, 16'hDEF0});
    end

    // Two 2-beat packets back to back
    log_q.delete();
    applyStimulus(64'h0004_0003_0002_0001, 1'b1, 1'b0, 3'd0, 10'd7);
    applyStimulus(64'h0008_0007_0006_0005, 1'b0, 1'b1, 3'd0, 10'd7);
    applyStimulus(64'h000C_000B_000A_0009, 1'b1, 1'b0, 3'd0, 10'd8);
    applyStimulus(64'h0010_000F_000E_000D, 1'b0, 1'b1, 3'd0, 10'd8);
    waitDrain();
    checkOutput("t4_count", 64'(log_q.size()), 64'd16);
    if (log_q.size() == 16) begin
      checkOutput("t4_span", 64'(log_q[15].cyc - log_q[0].cyc), 64'(SPAN16));
      checkOutput("t4_sop", {61'd0, log_q[0].sop, log_q[4].sop, log_q[8].sop}, 64'b101);
      checkOutput("t4_eop", {62'd0, log_q[7].eop, log_q[15].eop}, 64'b11);
      checkOutput("t4_word9", {48'd0, log_q[9].data}, 64'h000A);
    end

    // Random packets with random downstream ready
    ready_mode = 1;
    for (npk = 0; npk < 100; npk++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        applyStimulus({$urandom, $urandom}, (b == 0), (b == nb - 1),
                      3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)));
      end
    end
    ready_mode = 0;
    waitDrain();

    // Reset after word 1 of a beat
    log_q.delete();
    applyStimulus(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b0, 3'd0, 10'd3);
    for (int i = 0; i < 20 && log_q.size() < 2; i++) @(negedge clk);
    checkOutput("t6_words_before_reset", 64'(log_q.size()), 64'd2);
    @(posedge clk);
    #1;
    srst = 1'b1;
    @(negedge clk);
    checkOutput("t6_valid_in_reset", {63'd0, src_valid_o}, 64'd0);
    @(posedge clk);
    #1;
    srst = 1'b0;
    @(negedge clk);
    checkOutput("t6_after_reset", {62'd0, src_valid_o, snk_ready_o}, 64'b01);
    @(posedge clk);
    #1;
    log_q.delete();
    applyStimulus(64'h0004_0003_0002_0001, 1'b1, 1'b1, 3'd0, 10'd9);
    waitDrain();
    checkOutput("t6_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      checkOutput("t6_first", {47'd0, log_q[0].sop, log_q[0].data}, {47'd0, 1'b1, 16'h0001});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
